// File: rtl/password_sender_pkg.sv
// password_sender_pkg: FSM states, symbol one-hot codes and symbol-count constants
// shared by password_sender and pw_sym_encode.
package password_sender_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

    localparam logic [3:0] ONEHOT_00   = 4'b1000;
    localparam logic [3:0] ONEHOT_01   = 4'b0100;
    localparam logic [3:0] ONEHOT_10   = 4'b0010;
    localparam logic [3:0] ONEHOT_11   = 4'b0001;
    localparam logic [3:0] ONEHOT_NONE = 4'b0000;

    localparam int         NUM_SYMBOLS = 4;
    localparam logic [1:0] LAST_IDX    = 2'(NUM_SYMBOLS - 1);

    // Symbol i of a code; symbol0 sits in the top two bits.
    function automatic logic [1:0] sym_at(input logic [7:0] c, input logic [1:0] i);
        logic [7:0] sh;
        sh = c << {i, 1'b0};
        return sh[7:6];
    endfunction

endpackage

// File: rtl/password_sender_sym_encode.sv
// pw_sym_encode: maps a 2-bit symbol onto the one-hot button lines.
module pw_sym_encode
    import password_sender_pkg::*;
(
    input  logic [1:0] sym_i,
    output logic [3:0] onehot_o
);

    always_comb begin
        onehot_o = ONEHOT_NONE;
        case (sym_i)
            2'b00: onehot_o = ONEHOT_00;
            2'b01: onehot_o = ONEHOT_01;
            2'b10: onehot_o = ONEHOT_10;
            2'b11: onehot_o = ONEHOT_11;
            default: onehot_o = ONEHOT_NONE;
        endcase
    end

endmodule

// File: rtl/password_sender.sv
// password_sender: sends an 8-bit code as four one-hot button symbols with hold/gap timing.
// Optional abort input is enabled by defining PWSEND_ABORT_EN.
module password_sender
    import password_sender_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code,
    input  logic       start,
`ifdef PWSEND_ABORT_EN
    input  logic       abort,
`endif
    output logic [3:0] s,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t     state_q;
    logic [7:0] code_q;
    logic [7:0] cnt_q;
    logic [1:0] idx_q;
    logic [3:0] s_q;
    logic       busy_q;
    logic       done_q;

    logic [1:0] idx_d;
    logic [1:0] sym_d;
    logic [3:0] onehot_d;
    logic       abort_w;

`ifdef PWSEND_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // The encoder always looks at the symbol that will be shown next.
    assign idx_d = idx_q + 2'd1;
    assign sym_d = (state_q == IDLE) ? code[7:6] : sym_at(code_q, idx_d);

    pw_sym_encode u_enc (
        .sym_i    (sym_d),
        .onehot_o (onehot_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= 8'd0;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            s_q     <= ONEHOT_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DRIVE;
                        code_q  <= code;
                        cnt_q   <= 8'd0;
                        idx_q   <= 2'd0;
                        s_q     <= onehot_d;
                        busy_q  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (abort_w) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                        idx_q   <= 2'd0;
                        s_q     <= ONEHOT_NONE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_q <= 8'd0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            s_q     <= ONEHOT_NONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                            s_q     <= ONEHOT_NONE;
                        end else begin
                            idx_q <= idx_d;
                            s_q   <= onehot_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (abort_w) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                        idx_q   <= 2'd0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q <= DRIVE;
                        cnt_q   <= 8'd0;
                        idx_q   <= idx_d;
                        s_q     <= onehot_d;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s    = s_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_password_sender.sv
// tb_password_sender: two instances (H=1,G=0 and H=3,G=2) checked against a queue-based
// model of the expected per-cycle outputs, plus table vectors and corner-case sequences.
module tb_password_sender;

`ifdef PWSEND_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] s;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        logic       start;
        logic [7:0] code;
        logic [3:0] s;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] code = 8'd0;
    logic [3:0] s_a, s_b;
    logic       busy_a, busy_b, done_a, done_b;

    out_t q[2][$];
    out_t ex[2];
    int   hc[2] = '{1, 3};
    int   gc[2] = '{0, 2};
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tv[7];

    always #5 clk = ~clk;

    password_sender #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (code),
        .start (start),
`ifdef PWSEND_ABORT_EN
        .abort (abort),
`endif
        .s     (s_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    password_sender #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .code  (code),
        .start (start),
`ifdef PWSEND_ABORT_EN
        .abort (abort),
`endif
        .s     (s_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole transfer expressed as the list of outputs seen on each following cycle.
    task automatic model_edge();
        logic [1:0] sy;
        logic [3:0] oh;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                q[k].delete();
                ex[k] = '0;
                continue;
            end
            if (ABORT_EN && abort && ex[k].busy) begin
                q[k].delete();
            end else if (q[k].size() == 0 && start) begin
                for (int i = 0; i < 4; i++) begin
                    sy = code[7 - 2*i -: 2];
                    oh = 4'b1000 >> sy;
                    for (int h = 0; h < hc[k]; h++) q[k].push_back({oh, 1'b1, 1'b0});
                    if (i < 3) for (int g = 0; g < gc[k]; g++) q[k].push_back({4'b0000, 1'b1, 1'b0});
                end
                q[k].push_back({4'b0000, 1'b0, 1'b1});
                q[k].push_back({4'b0000, 1'b0, 1'b0});
            end
            ex[k] = (q[k].size() != 0) ? q[k].pop_front() : '0;
        end
    endtask

    task automatic compare_all();
        chk("a_s", int'(s_a), int'(ex[0].s));
        chk("a_busy", int'(busy_a), int'(ex[0].busy));
        chk("a_done", int'(done_a), int'(ex[0].done));
        chk("b_s", int'(s_b), int'(ex[1].s));
        chk("b_busy", int'(busy_b), int'(ex[1].busy));
        chk("b_done", int'(done_b), int'(ex[1].done));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && ex[0] == '0 && ex[1] == '0) break;
            step();
        end
        chk("drain_busy_a", int'(busy_a), 0);
        chk("drain_busy_b", int'(busy_b), 0);
    endtask

    initial begin
        int nb, nd_a, nd_b;
        logic [3:0] seq[4];
        tv[0] = '{1'b1, 8'h1B, 4'b1000, 1'b1, 1'b0};
        tv[1] = '{1'b0, 8'h1B, 4'b0100, 1'b1, 1'b0};
        tv[2] = '{1'b0, 8'h1B, 4'b0010, 1'b1, 1'b0};
        tv[3] = '{1'b0, 8'h1B, 4'b0001, 1'b1, 1'b0};
        tv[4] = '{1'b0, 8'h1B, 4'b0000, 1'b0, 1'b1};
        tv[5] = '{1'b0, 8'h1B, 4'b0000, 1'b0, 1'b0};
        tv[6] = '{1'b0, 8'h1B, 4'b0000, 1'b0, 1'b0};
        ex[0] = '0;
        ex[1] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Back-to-back symbols with default timing
        for (int i = 0; i < 7; i++) begin
            start = tv[i].start;
            code  = tv[i].code;
            step();
            chk("tbl_s", int'(s_a), int'(tv[i].s));
            chk("tbl_busy", int'(busy_a), int'(tv[i].busy));
            chk("tbl_done", int'(done_a), int'(tv[i].done));
        end
        drain();

        // Hold/gap timing and busy length
        code = 8'hE4;
        start = 1'b1;
        nb = 0;
        nd_b = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            start = 1'b0;
            nb += int'(busy_b);
            nd_b += int'(done_b);
        end
        chk("b_busy_len", nb, 18);
        chk("b_done_cnt", nd_b, 1);
        drain();

        // Start held high: restarts only from IDLE
        code = 8'hFF;
        start = 1'b1;
        nd_a = 0;
        nd_b = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            nd_a += int'(done_a);
            nd_b += int'(done_b);
        end
        chk("held_done_a", nd_a, 5);
        chk("held_done_b", nd_b, 1);
        start = 1'b0;
        drain();

        // Code changes after latching
        code = 8'h1B;
        start = 1'b1;
        step();
        seq[0] = s_a;
        start = 1'b0;
        code = 8'hE4;
        for (int i = 1; i < 4; i++) begin
            step();
            seq[i] = s_a;
        end
        chk("latch_s0", int'(seq[0]), 8);
        chk("latch_s1", int'(seq[1]), 4);
        chk("latch_s2", int'(seq[2]), 2);
        chk("latch_s3", int'(seq[3]), 1);
        drain();

        // Asynchronous reset during symbol2
        code = 8'h1B;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_s_a", int'(s_a), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_s_a", int'(s_a), 0);
        chk("rst_async_busy_a", int'(busy_a), 0);
        chk("rst_async_s_b", int'(s_b), 0);
        chk("rst_async_busy_b", int'(busy_b), 0);
        q[0].delete();
        q[1].delete();
        ex[0] = '0;
        ex[1] = '0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        code = 8'h36;
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

`ifdef PWSEND_ABORT_EN
        // Abort in the first gap cycle of instance B
        code = 8'hE4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("gap_entry_busy_b", int'(busy_b), 1);
        chk("gap_entry_s_b", int'(s_b), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_b", int'(busy_b), 0);
        chk("abort_s_b", int'(s_b), 0);
        nd_b = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            nd_b += int'(done_b);
        end
        chk("abort_no_done_b", nd_b, 0);
        code = 8'h1B;
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) == 0);
            code  = 8'($urandom);
            abort = ABORT_EN && ($urandom_range(0, 15) == 0);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/password_sender.md
PASSWORD_SENDER -- requirements
Module: password_sender

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: clock cycles each symbol is driven on s; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 0: clock cycles of s=4'b0000 between consecutive symbols; legal range 0..255.
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 code  input  8  code to send: symbol0=[7:6], symbol1=[5:4], symbol2=[3:2], symbol3=[1:0].
REQ-006 start  input  1  request to send code; sampled only in IDLE.
REQ-007 s  output  4  one-hot button lines, registered output.
REQ-008 busy  output  1  high from the cycle after an accepted start until the done cycle, exclusive.
REQ-009 done  output  1  one-cycle pulse after the last symbol is sent.

Function
REQ-010 Symbol encoding SHALL be 2'b00->4'b1000, 2'b01->4'b0100, 2'b10->4'b0010, 2'b11->4'b0001; s SHALL be 4'b0000 whenever no symbol is driven.
REQ-011 FSM states SHALL be IDLE, DRIVE, GAP, DONE.
REQ-012 IDLE: start=1 at an edge SHALL latch code into an internal register, clear the symbol index, and enter DRIVE; s shows symbol0 and busy=1 from the next cycle.
REQ-013 DRIVE: s SHALL hold the current symbol for exactly HOLD_CYCLES cycles, then go to GAP if index<3 and GAP_CYCLES>0, go to DRIVE with index+1 if index<3 and GAP_CYCLES=0, or go to DONE if index=3.
REQ-014 GAP: s=4'b0000 for exactly GAP_CYCLES cycles, then go to DRIVE with index+1.
REQ-015 DONE: s=4'b0000, done=1, busy=0 for one cycle, then go to IDLE.
REQ-016 No gap SHALL follow symbol3; total busy length SHALL be 4*HOLD_CYCLES+3*GAP_CYCLES cycles.
REQ-017 start while not in IDLE, including in the DONE cycle, SHALL be ignored; it is not queued.
REQ-018 Changes on code after latching SHALL NOT affect the transfer in progress.
REQ-019 The hold/gap counter SHALL be 8 bits; the symbol index SHALL be 2 bits; neither counter SHALL wrap during legal operation.
REQ-020 With HOLD_CYCLES=1 and GAP_CYCLES=0, the block SHALL emit the four symbols on four consecutive cycles, one symbol per clock.

Reset
REQ-021 rst_n=0 SHALL force, asynchronously: state=IDLE, s=4'b0000, busy=0, done=0, counters=0, latched code=0.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; after release the block SHALL wait for a new start.

Configuration
REQ-023 Macro PWSEND_ABORT_EN: when defined, the block SHALL add input abort (1 bit); abort=1 in DRIVE or GAP SHALL return the FSM to IDLE at the next edge with s=4'b0000, busy=0, and no done pulse; abort SHALL be ignored in IDLE and DONE.
REQ-024 When PWSEND_ABORT_EN is undefined, port abort SHALL NOT exist and transfers SHALL always run to completion.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE, DRIVE, GAP, DONE), the symbol-to-one-hot constants, and the symbol count constant (4).
REQ-026 The 2-bit-to-one-hot encoder SHALL be a sub-module named pw_sym_encode; all other logic SHALL remain in password_sender.

Verification
REQ-027 Defaults, code=8'b00_01_10_11, start pulse: s=1000,0100,0010,0001 on 4 consecutive cycles, then done=1 for one cycle; busy high for exactly 4 cycles.
REQ-028 HOLD_CYCLES=3, GAP_CYCLES=2, code=8'hE4: s=0001 x3, 0000 x2, 0010 x3, 0000 x2, 0100 x3, 0000 x2, 1000 x3, then done; busy high for 18 cycles.
REQ-029 start held high continuously, code=8'hFF: four 0001 cycles, a done pulse, and a new transfer starting the cycle after DONE; no start accepted mid-transfer.
REQ-030 rst_n pulled low during symbol2, async to clk: s=0000 and busy=0 immediately; no done; idle until next start.
REQ-031 code changed from 8'h1B to 8'hE4 one cycle after start: sequence still 1000,0100,0010,0001.
REQ-032 With PWSEND_ABORT_EN defined, abort=1 during the first GAP cycle: next cycle s=0000, busy=0, done never asserted; a subsequent start runs normally.
